// File: rtl/uart_pkg.sv
// Shared encodings, FSM state and helpers for the UART receiver.
package uart_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BIT_IDX_W = 3;

  typedef enum logic [1:0] {
    DATA_BITS_8 = 2'd0,
    DATA_BITS_7 = 2'd1,
    DATA_BITS_6 = 2'd2,
    DATA_BITS_5 = 2'd3
  } data_bits_t;

  typedef enum logic [1:0] {
    STOP_BITS_1     = 2'd0,
    STOP_BITS_1P5   = 2'd1,
    STOP_BITS_2     = 2'd2,
    STOP_BITS_2_ALT = 2'd3
  } stop_bits_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_rx_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Index of the final data bit: 8 data bits -> 7, 5 data bits -> 4.
  function automatic logic [BIT_IDX_W-1:0] last_bit_idx(input data_bits_t db);
    return BIT_IDX_W'(3'd7 - {1'b0, db});
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rxd synchroniser with optional 3-sample majority filter (UART_RX_MAJORITY_EN).
module uart_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic baud_clk_i,
  input  logic rxd_i,
  output logic rxd_sync_o,
  output logic rxd_s_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd_i};
    end
  end

  assign rxd_sync_o = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  // History of the last three baud-tick samples; the FSM samples two ticks late to centre it.
  logic [2:0] hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '1;
    end else if (baud_clk_i) begin
      hist_q <= {hist_q[1:0], rxd_sync_o};
    end
  end

  assign rxd_s_o = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
`else
  logic unused_baud_clk;
  assign unused_baud_clk = baud_clk_i;
  assign rxd_s_o         = rxd_sync_o;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 5-8 data bits, optional parity, AXI-Stream byte output.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority bit sampling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DATA_W-1:0] m_axis_rx_tdata,
  output logic              m_axis_rx_tvalid,
  input  logic              m_axis_rx_tready,
  input  logic [1:0]        data_bits,
  input  logic [1:0]        stop_bits,
  input  logic              parity_en,
  input  logic              parity_type,
  input  logic              rxd,
  output logic              busy,
  input  logic              baud_clk,
  output logic              frame_error,
  output logic              parity_error,
  output logic              overrun_error
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] SAMPLE_TICK = CNT_W'(OVERSAMPLE / 2 + 1);
`else
  localparam logic [CNT_W-1:0] SAMPLE_TICK = CNT_W'(OVERSAMPLE / 2 - 1);
`endif

  // The receiver only samples the first stop bit; extra stop time is idle line.
  logic unused_stop_bits;
  assign unused_stop_bits = ^stop_bits;

  logic rxd_sync;
  logic rxd_s;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst        (rst),
    .baud_clk_i (baud_clk),
    .rxd_i      (rxd),
    .rxd_sync_o (rxd_sync),
    .rxd_s_o    (rxd_s)
  );

  uart_rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_IDX_W-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  data_bits_t             db_q, db_d;
  logic                   par_en_q, par_en_d;
  logic                   par_type_q, par_type_d;
  logic                   par_bad_q, par_bad_d;
  logic                   brk_q, brk_d;
  logic [DATA_W-1:0]      tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   busy_q, busy_d;
  logic                   ferr_q, ferr_d;
  logic                   perr_q, perr_d;
  logic                   oerr_q, oerr_d;
  logic                   done_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      db_q       <= DATA_BITS_8;
      par_en_q   <= 1'b0;
      par_type_q <= PARITY_EVEN;
      par_bad_q  <= 1'b0;
      brk_q      <= 1'b0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      busy_q     <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      oerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      db_q       <= db_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      par_bad_q  <= par_bad_d;
      brk_q      <= brk_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      busy_q     <= busy_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      oerr_q     <= oerr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    db_d       = db_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    par_bad_d  = par_bad_q;
    brk_d      = brk_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    ferr_d     = 1'b0;
    perr_d     = 1'b0;
    oerr_d     = 1'b0;
    done_c     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!rxd_sync) begin
          state_d    = ST_START;
          cnt_d      = '0;
          bit_d      = '0;
          shift_d    = '0;
          par_bad_d  = 1'b0;
          brk_d      = 1'b0;
          db_d       = data_bits_t'(data_bits);
          par_en_d   = parity_en;
          par_type_d = parity_type;
        end
      end

      // A high sample at mid start bit is a glitch; a low one re-phases the tick count.
      ST_START: begin
        if (baud_clk) begin
          if (cnt_q == SAMPLE_TICK) begin
            cnt_d   = '0;
            state_d = rxd_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (baud_clk) begin
          if (cnt_q == LAST_TICK) begin
            cnt_d          = '0;
            shift_d[bit_q] = rxd_s;
            if (bit_q == last_bit_idx(db_q)) begin
              state_d = par_en_q ? ST_PARITY : ST_STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_PARITY: begin
        if (baud_clk) begin
          if (cnt_q == LAST_TICK) begin
            cnt_d     = '0;
            par_bad_d = rxd_s != (^shift_q ^ par_type_q);
            state_d   = ST_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      // After a low stop bit, hold here until the line returns high.
      ST_STOP: begin
        if (brk_q) begin
          if (rxd_sync) begin
            brk_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end else if (baud_clk) begin
          if (cnt_q == LAST_TICK) begin
            cnt_d   = '0;
            done_c  = 1'b1;
            ferr_d  = ~rxd_s;
            perr_d  = par_bad_q;
            brk_d   = ~rxd_s;
            state_d = rxd_s ? ST_IDLE : ST_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Output register: handshake drains the slot; a completed frame refills it or overruns.
    if (tvalid_q && m_axis_rx_tready) begin
      tvalid_d = 1'b0;
    end
    if (done_c) begin
      if (!tvalid_q || m_axis_rx_tready) begin
        tdata_d  = shift_q;
        tvalid_d = 1'b1;
      end else begin
        oerr_d = 1'b1;
      end
    end

    busy_d = state_d != ST_IDLE;
  end

  assign m_axis_rx_tdata  = tdata_q;
  assign m_axis_rx_tvalid = tvalid_q;
  assign busy             = busy_q;
  assign frame_error      = ferr_q;
  assign parity_error     = perr_q;
  assign overrun_error    = oerr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: baud_clk every 4 clk, 8x oversample -> 32 clk per bit.
module tb_uart_rx;

  localparam int unsigned BIT_CLKS = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready = 1'b1;
  logic [1:0] data_bits = 2'd0;
  logic [1:0] stop_bits = 2'd0;
  logic       parity_en = 1'b0;
  logic       parity_type = 1'b0;
  logic       rxd = 1'b1;
  logic       busy;
  logic       baud_clk = 1'b0;
  logic       frame_error;
  logic       parity_error;
  logic       overrun_error;

  int n_tests = 0;
  int n_fail  = 0;

  int beats = 0;
  int ferrs = 0;
  int perrs = 0;
  int oerrs = 0;
  logic [7:0] last_beat = 8'h00;
  int bdiv = 0;

  uart_rx dut (
    .clk              (clk),
    .rst              (rst),
    .m_axis_rx_tdata  (tdata),
    .m_axis_rx_tvalid (tvalid),
    .m_axis_rx_tready (tready),
    .data_bits        (data_bits),
    .stop_bits        (stop_bits),
    .parity_en        (parity_en),
    .parity_type      (parity_type),
    .rxd              (rxd),
    .busy             (busy),
    .baud_clk         (baud_clk),
    .frame_error      (frame_error),
    .parity_error     (parity_error),
    .overrun_error    (overrun_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bdiv     <= (bdiv == 3) ? 0 : bdiv + 1;
    baud_clk <= (bdiv == 3);
  end

  // Pre-edge values: handshakes and one-clk error pulses each seen exactly once.
  always @(posedge clk) begin
    if (tvalid && tready) begin
      beats     = beats + 1;
      last_beat = tdata;
    end
    if (frame_error)   ferrs = ferrs + 1;
    if (parity_error)  perrs = perrs + 1;
    if (overrun_error) oerrs = oerrs + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic pen,
                            input logic pbit, input logic stopv, input int stop_clks);
    rxd = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < nbits; i++) begin
      rxd = d[i];
      wait_clks(BIT_CLKS);
    end
    if (pen) begin
      rxd = pbit;
      wait_clks(BIT_CLKS);
    end
    rxd = stopv;
    wait_clks(stop_clks);
    rxd = 1'b1;
  endtask

  int b0, f0, p0, o0;

  task automatic snap();
    b0 = beats;
    f0 = ferrs;
    p0 = perrs;
    o0 = oerrs;
  endtask

  initial begin
    wait_clks(5);
    check_eq("rst_tvalid", 32'(tvalid), 32'd0);
    check_eq("rst_tdata", 32'(tdata), 32'h00);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ferr", 32'(frame_error), 32'd0);
    check_eq("rst_perr", 32'(parity_error), 32'd0);
    check_eq("rst_oerr", 32'(overrun_error), 32'd0);
    rst = 1'b0;
    wait_clks(BIT_CLKS);

    // 8N1 0x55
    snap();
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, BIT_CLKS);
    wait_clks(2 * BIT_CLKS);
    check_eq("8n1_beats", 32'(beats - b0), 32'd1);
    check_eq("8n1_data", 32'(last_beat), 32'h55);
    check_eq("8n1_ferr", 32'(ferrs - f0), 32'd0);
    check_eq("8n1_perr", 32'(perrs - p0), 32'd0);
    check_eq("8n1_busy", 32'(busy), 32'd0);
    check_eq("8n1_tvalid", 32'(tvalid), 32'd0);

    // 7E1.5 0x3F, even parity bit 0
    data_bits = 2'd1; parity_en = 1'b1; parity_type = 1'b0; stop_bits = 2'd1;
    snap();
    send_frame(8'h3F, 7, 1'b1, 1'b0, 1'b1, BIT_CLKS + BIT_CLKS / 2);
    wait_clks(2 * BIT_CLKS);
    check_eq("7e1_beats", 32'(beats - b0), 32'd1);
    check_eq("7e1_data", 32'(last_beat), 32'h3F);
    check_eq("7e1_perr", 32'(perrs - p0), 32'd0);

    // 8O2 0xAA with wrong parity bit 0
    data_bits = 2'd0; parity_en = 1'b1; parity_type = 1'b1; stop_bits = 2'd2;
    snap();
    send_frame(8'hAA, 8, 1'b1, 1'b0, 1'b1, 2 * BIT_CLKS);
    wait_clks(2 * BIT_CLKS);
    check_eq("8o2_beats", 32'(beats - b0), 32'd1);
    check_eq("8o2_data", 32'(last_beat), 32'hAA);
    check_eq("8o2_perr", 32'(perrs - p0), 32'd1);
    check_eq("8o2_ferr", 32'(ferrs - f0), 32'd0);

    // Start-bit glitch: low for 2 baud ticks
    data_bits = 2'd0; parity_en = 1'b0; parity_type = 1'b0; stop_bits = 2'd0;
    snap();
    rxd = 1'b0;
    wait_clks(6);
    check_eq("glitch_busy_hi", 32'(busy), 32'd1);
    wait_clks(2);
    rxd = 1'b1;
    wait_clks(2 * BIT_CLKS);
    check_eq("glitch_beats", 32'(beats - b0), 32'd0);
    check_eq("glitch_busy_lo", 32'(busy), 32'd0);
    check_eq("glitch_errs", 32'((ferrs - f0) + (perrs - p0)), 32'd0);

    // 8N1 0x12 with low stop bit, line held low 20 bit times
    snap();
    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b0, 20 * BIT_CLKS);
    check_eq("brk_beats", 32'(beats - b0), 32'd1);
    check_eq("brk_data", 32'(last_beat), 32'h12);
    check_eq("brk_ferr", 32'(ferrs - f0), 32'd1);
    check_eq("brk_busy", 32'(busy), 32'd1);
    wait_clks(BIT_CLKS);
    check_eq("brk_release", 32'(busy), 32'd0);
    snap();
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, BIT_CLKS);
    wait_clks(2 * BIT_CLKS);
    check_eq("post_brk_data", 32'(last_beat), 32'hC3);
    check_eq("post_brk_beats", 32'(beats - b0), 32'd1);
    check_eq("post_brk_ferr", 32'(ferrs - f0), 32'd0);

    // Overrun: tready low across two frames
    tready = 1'b0;
    snap();
    send_frame(8'h01, 8, 1'b0, 1'b0, 1'b1, BIT_CLKS);
    wait_clks(BIT_CLKS);
    check_eq("ovr_first_valid", 32'(tvalid), 32'd1);
    check_eq("ovr_first_oerr", 32'(oerrs - o0), 32'd0);
    send_frame(8'h02, 8, 1'b0, 1'b0, 1'b1, BIT_CLKS);
    wait_clks(BIT_CLKS);
    check_eq("ovr_tdata_held", 32'(tdata), 32'h01);
    check_eq("ovr_oerr", 32'(oerrs - o0), 32'd1);
    check_eq("ovr_no_beat", 32'(beats - b0), 32'd0);
    tready = 1'b1;
    wait_clks(2);
    check_eq("ovr_drain_beats", 32'(beats - b0), 32'd1);
    check_eq("ovr_drain_data", 32'(last_beat), 32'h01);
    check_eq("ovr_drain_valid", 32'(tvalid), 32'd0);

    // Reset mid-DATA while a byte is held, then recover
    tready = 1'b0;
    send_frame(8'h77, 8, 1'b0, 1'b0, 1'b1, BIT_CLKS);
    wait_clks(BIT_CLKS);
    rxd = 1'b0;
    wait_clks(BIT_CLKS);
    rxd = 1'b1;
    wait_clks(BIT_CLKS);
    rxd = 1'b0;
    wait_clks(BIT_CLKS / 2);
    check_eq("mid_busy", 32'(busy), 32'd1);
    check_eq("mid_valid", 32'(tvalid), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_valid", 32'(tvalid), 32'd0);
    check_eq("mid_rst_tdata", 32'(tdata), 32'h00);
    rxd = 1'b1;
    tready = 1'b1;
    wait_clks(4);
    rst = 1'b0;
    wait_clks(BIT_CLKS);
    snap();
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, BIT_CLKS);
    wait_clks(2 * BIT_CLKS);
    check_eq("post_rst_beats", 32'(beats - b0), 32'd1);
    check_eq("post_rst_data", 32'(last_beat), 32'h5A);
    check_eq("post_rst_errs", 32'((ferrs - f0) + (perrs - p0) + (oerrs - o0)), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
